tiny_dnn_seq: RTL and testbench

TINY_DNN_SEQ -- requirements
Module: tiny_dnn_seq

---
 rtl/tiny_dnn_pkg.sv | 24 ++
 rtl/tiny_dnn_addr_gen.sv | 51 +++++
 rtl/tiny_dnn_seq.sv | 171 +++++++++++++++++
 tb/tb_tiny_dnn_seq.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/tiny_dnn_pkg.sv
// Shared types and widths for the tiny DNN MAC-core sequencer.
package tiny_dnn_pkg;

  localparam int ADDR_W = 10;
  localparam int DA_W   = 22;
  localparam int SS_W   = 10;
  localparam int OC_W   = 6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    EXEC  = 3'd2,
    BIAS  = 3'd3,
    DRAIN = 3'd4,
    OUT   = 3'd5,
    DONE  = 3'd6
  } seq_state_t;

  // An output-chain length of zero still needs one shift to emit the result.
  function automatic logic [OC_W-1:0] oc_eff(input logic [OC_W-1:0] oc);
    return (oc == 6'd0) ? 6'd1 : oc;
  endfunction

endpackage

// File: rtl/tiny_dnn_addr_gen.sv
// Term, pixel and running-base counters; produces the next-cycle weight index and buffer address.
module tiny_dnn_addr_gen
  import tiny_dnn_pkg::*;
#(
  parameter int NPIX_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              exec_nxt_i,
  input  logic              in_exec_i,
  input  logic              pix_adv_i,
  input  logic [SS_W-1:0]   ss_i,
  output logic [SS_W-1:0]   k_o,
  output logic [SS_W-1:0]   k_nxt_o,
  output logic [DA_W-1:0]   da_nxt_o,
  output logic [NPIX_W-1:0] pix_o
);

  logic [SS_W-1:0]   k_q;
  logic [NPIX_W-1:0] pix_q;
  logic [DA_W-1:0]   base_q;

  // EXEC is only entered from INIT, so being in EXEC already means the term index advances.
  always_comb begin
    k_nxt_o  = in_exec_i ? (k_q + 10'd1) : 10'd0;
    da_nxt_o = base_q + DA_W'(k_nxt_o);
  end

  // base tracks pix*ss by accumulation; the 22-bit add wraps modulo 2^22.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q    <= 10'd0;
      pix_q  <= '0;
      base_q <= 22'd0;
    end else begin
      k_q <= exec_nxt_i ? k_nxt_o : 10'd0;
      if (clr_i) begin
        pix_q  <= '0;
        base_q <= 22'd0;
      end else if (pix_adv_i) begin
        pix_q  <= pix_q + NPIX_W'(1);
        base_q <= base_q + DA_W'(ss_i);
      end
    end
  end

  assign k_o   = k_q;
  assign pix_o = pix_q;

endmodule

// File: rtl/tiny_dnn_seq.sv
// Run sequencer for a chain of MAC cores: init, ss exec terms, optional bias, drain, output shifts.
module tiny_dnn_seq
  import tiny_dnn_pkg::*;
#(
  parameter int F_SIZE = 1024,
  parameter int NPIX_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [SS_W-1:0]   ss_i,
  input  logic [NPIX_W-1:0] npix_i,
  input  logic [OC_W-1:0]   oc_i,
  input  logic              bias_en_i,
  input  logic              bank_i,
  output logic              init_o,
  output logic              exec_o,
  output logic              bias_o,
  output logic              outr_o,
  output logic              update_o,
  output logic [ADDR_W:0]   ra_o,
  output logic [DA_W-1:0]   da_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [ADDR_W-1:0] K_MASK = ADDR_W'(F_SIZE - 1);

  seq_state_t        state_q, state_d, post_init_s;
  logic [SS_W-1:0]   ss_q;
  logic [NPIX_W-1:0] npix_q;
  logic [OC_W-1:0]   oc_q, cnt_q, cnt_d;
  logic              bias_en_q, bank_q;
  logic              start_acc_s, pix_adv_s;
  logic [SS_W-1:0]   k_s, k_nxt_s;
  logic [DA_W-1:0]   da_nxt_s;
  logic [NPIX_W-1:0] pix_s;
  logic              init_q, exec_q, bias_q, outr_q, update_q, busy_q, done_q;
  logic [ADDR_W:0]   ra_q, ra_d;
  logic [DA_W-1:0]   da_q, da_d;

  assign start_acc_s = (state_q == IDLE) && start_i;

  tiny_dnn_addr_gen #(.NPIX_W(NPIX_W)) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (start_acc_s),
    .exec_nxt_i (state_d == EXEC),
    .in_exec_i  (state_q == EXEC),
    .pix_adv_i  (pix_adv_s),
    .ss_i       (ss_q),
    .k_o        (k_s),
    .k_nxt_o    (k_nxt_s),
    .da_nxt_o   (da_nxt_s),
    .pix_o      (pix_s)
  );

  // Next-state decode; strobe and address registers are loaded from the next state.
  always_comb begin
    state_d   = state_q;
    pix_adv_s = 1'b0;
    if (ss_q != 10'd0) begin
      post_init_s = EXEC;
    end else if (bias_en_q) begin
      post_init_s = BIAS;
    end else begin
      post_init_s = DRAIN;
    end
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = (npix_i == '0) ? DONE : INIT;
        end else begin
          state_d = IDLE;
        end
      end
      INIT: state_d = post_init_s;
      EXEC: begin
        if (k_s == ss_q - 10'd1) begin
          state_d = bias_en_q ? BIAS : DRAIN;
        end else begin
          state_d = EXEC;
        end
      end
      BIAS: state_d = DRAIN;
      DRAIN: begin
        if (cnt_q == 6'd1) begin
          state_d = OUT;
        end else begin
          state_d = DRAIN;
        end
      end
      OUT: begin
        if (cnt_q == oc_q - 6'd1) begin
          pix_adv_s = 1'b1;
          state_d   = ((pix_s + NPIX_W'(1)) == npix_q) ? DONE : INIT;
        end else begin
          state_d = OUT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cnt_d = (state_d == state_q) ? (cnt_q + 6'd1) : 6'd0;

    case (state_d)
      EXEC:    ra_d = {bank_q, k_nxt_s & K_MASK};
      BIAS:    ra_d = {bank_q, 10'd0};
      default: ra_d = ra_q;
    endcase

    if (state_d == EXEC) begin
      da_d = da_nxt_s;
    end else begin
      da_d = da_q;
    end
  end

  // State, latched run parameters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ss_q      <= 10'd0;
      npix_q    <= '0;
      oc_q      <= 6'd0;
      bias_en_q <= 1'b0;
      bank_q    <= 1'b0;
      cnt_q     <= 6'd0;
      init_q    <= 1'b0;
      exec_q    <= 1'b0;
      bias_q    <= 1'b0;
      outr_q    <= 1'b0;
      update_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ra_q      <= 11'd0;
      da_q      <= 22'd0;
    end else begin
      if (start_acc_s) begin
        ss_q      <= ss_i;
        npix_q    <= npix_i;
        oc_q      <= oc_eff(oc_i);
        bias_en_q <= bias_en_i;
        bank_q    <= bank_i;
      end
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      init_q   <= (state_d == INIT);
      exec_q   <= (state_d == EXEC);
      bias_q   <= (state_d == BIAS);
      outr_q   <= (state_d == OUT);
      update_q <= (state_d == OUT) && (state_q != OUT);
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_d == DONE);
      ra_q     <= ra_d;
      da_q     <= da_d;
    end
  end

  assign init_o   = init_q;
  assign exec_o   = exec_q;
  assign bias_o   = bias_q;
  assign outr_o   = outr_q;
  assign update_o = update_q;
  assign ra_o     = ra_q;
  assign da_o     = da_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_tiny_dnn_seq.sv
// Scoreboard bench for tiny_dnn_seq: a cycle-by-cycle reference waveform is queued per run.
module tb_tiny_dnn_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  ss = 10'd0;
  logic [11:0] npix = 12'd0;
  logic [5:0]  oc = 6'd0;
  logic        bias_en = 1'b0;
  logic        bank = 1'b0;
  logic        init, exec, bias, outr, update, busy, done;
  logic [10:0] ra;
  logic [21:0] da;

  tiny_dnn_seq #(.F_SIZE(1024), .NPIX_W(12)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start),
    .ss_i      (ss),
    .npix_i    (npix),
    .oc_i      (oc),
    .bias_en_i (bias_en),
    .bank_i    (bank),
    .init_o    (init),
    .exec_o    (exec),
    .bias_o    (bias),
    .outr_o    (outr),
    .update_o  (update),
    .ra_o      (ra),
    .da_o      (da),
    .busy_o    (busy),
    .done_o    (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        chk_ra;
    logic [39:0] v;
  } exp_t;

  exp_t        q[$];
  int          n_assert = 0;
  int          n_fail = 0;
  logic [21:0] m_da = 22'd0;

  function automatic logic [39:0] obs_vec();
    return {busy, done, init, exec, bias, outr, update, ra, da};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic void push(input logic bsy, dn, ini, exe, bia, outr_e, upd,
                               input logic [10:0] r, input logic chk, input logic [21:0] d);
    exp_t e;
    e.chk_ra = chk;
    e.v      = {bsy, dn, ini, exe, bia, outr_e, upd, r, d};
    q.push_back(e);
  endfunction

  // Reference waveform: init, ss exec terms, optional bias, 2 drain, oc outputs per pixel.
  task automatic model_run(input int s, input int n, input int o, input logic b, input logic bk);
    int oe;
    oe = (o == 0) ? 1 : o;
    for (int p = 0; p < n; p++) begin
      push(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 1'b0, m_da);
      for (int k = 0; k < s; k++) begin
        m_da = 22'(p * s + k);
        push(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, {bk, 10'(k)}, 1'b1, m_da);
      end
      if (b) push(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, {bk, 10'd0}, 1'b1, m_da);
      repeat (2) push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 1'b0, m_da);
      for (int j = 0; j < oe; j++)
        push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, (j == 0), 11'd0, 1'b0, m_da);
    end
    push(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 1'b0, m_da);
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 1'b0, m_da);
  endtask

  task automatic do_run(input logic [9:0] s, input logic [11:0] n, input logic [5:0] o,
                        input logic b, input logic bk, input bit disturb, input string tag);
    exp_t        e;
    logic [39:0] obs;
    int          cyc;
    model_run(int'(s), int'(n), int'(o), b, bk);
    @(posedge clk); #1;
    ss = s; npix = n; oc = o; bias_en = b; bank = bk; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (q.size() > 0) begin
      @(negedge clk);
      e   = q.pop_front();
      obs = obs_vec();
      if (!e.chk_ra) obs[32:22] = e.v[32:22];
      check($sformatf("%s cyc%0d", tag, cyc), 64'(obs), 64'(e.v));
      if (disturb) begin
        if (cyc == 2) begin
          ss = ~s; npix = n + 12'd7; oc = o + 6'd3; bias_en = ~b; bank = ~bk;
        end
        if (cyc == 4) start = 1'b1;
        if (cyc == 5) start = 1'b0;
      end
      cyc++;
    end
  endtask

  // Strobe exclusivity on every cycle outside reset.
  always @(negedge clk) begin
    if (rst_n) begin
      n_assert++;
      assert ($countones({init, exec, bias, outr}) <= 1) else begin
        n_fail++;
        $error("FAIL strobe_excl: observed %b expected at most one set", {init, exec, bias, outr});
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 64'(obs_vec()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_run(10'd3, 12'd1, 6'd2, 1'b1, 1'b1, 1'b0, "ex1");
    do_run(10'd4, 12'd3, 6'd1, 1'b0, 1'b0, 1'b0, "ex2");
    do_run(10'd0, 12'd2, 6'd3, 1'b1, 1'b0, 1'b0, "biasonly");
    do_run(10'd2, 12'd0, 6'd2, 1'b1, 1'b0, 1'b0, "npix0");
    do_run(10'd2, 12'd2, 6'd0, 1'b0, 1'b1, 1'b0, "oc0");
    do_run(10'd5, 12'd2, 6'd2, 1'b1, 1'b0, 1'b1, "disturbed");

    // Abort in the second EXEC cycle, then a clean rerun.
    @(posedge clk); #1;
    ss = 10'd3; npix = 12'd2; oc = 6'd1; bias_en = 1'b0; bank = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("abort_exec", 64'(exec), 64'd1);
    check("abort_da", 64'(da), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_async", 64'(obs_vec()), 64'd0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", 64'(done), 64'd0);
    end
    rst_n = 1'b1;
    m_da = 22'd0;
    q.delete();
    do_run(10'd3, 12'd2, 6'd1, 1'b0, 1'b0, 1'b0, "rerun");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
